// File: rtl/scan_chain_ctrl.sv
// scan_chain_ctrl
// Posedge controller for a single chain of negedge-triggered scan flops.
// A run shifts PAT_IN into the chain MSB first, spends one cycle with SE low
// so the chain captures its functional D, unloads the response, and compares
// it against EXP_IN.
//
// Ports
//   CLK       clock (posedge only)
//   RST       synchronous active-high reset; aborts a run, chain untouched
//   START     begin a run; sampled only while idle
//   PAT_IN    pattern; bit i lands in chain flop i (flop 0 nearest SI)
//   EXP_IN    expected captured response
//   MASK_IN   compare mask, present only with SCAN_CHAIN_CTRL_MASK_EN
//   SO        Q of the last chain flop
//   SE, SI    scan enable / scan data into flop 0
//   BUSY      high while a run is in progress
//   DONE      one-cycle pulse; CAP_OUT and MISMATCH valid from here on
//   CAP_OUT   captured response; bit i comes from chain flop i
//   MISMATCH  compared bits of CAP_OUT differ from the latched EXP_IN
//
// Build option: define SCAN_CHAIN_CTRL_MASK_EN to add MASK_IN. Bits whose
// latched mask is 0 are excluded from MISMATCH; CAP_OUT still reports them.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | waiting for START; SE low
// S_SHIFT   | CHAIN_LEN cycles driving pattern bits onto SI, SE high
// S_CAPTURE | one cycle with SE low; chain captures functional D
// S_UNLOAD  | CHAIN_LEN-1 cycles shifting the response out, SI held low
// S_DONE    | DONE pulse; results registered on entry

module scan_chain_ctrl #(
  parameter int CHAIN_LEN = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 START,
  input  logic [CHAIN_LEN-1:0] PAT_IN,
  input  logic [CHAIN_LEN-1:0] EXP_IN,
`ifdef SCAN_CHAIN_CTRL_MASK_EN
  input  logic [CHAIN_LEN-1:0] MASK_IN,
`endif
  input  logic                 SO,
  output logic                 SE,
  output logic                 SI,
  output logic                 BUSY,
  output logic                 DONE,
  output logic [CHAIN_LEN-1:0] CAP_OUT,
  output logic                 MISMATCH
);

  localparam int CW = $clog2(CHAIN_LEN) + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHIFT,
    S_CAPTURE,
    S_UNLOAD,
    S_DONE
  } state_t;

  state_t               state;
  logic [CW-1:0]        cnt;
  logic [CHAIN_LEN-1:0] pat_sr;
  logic [CHAIN_LEN-1:0] exp_q;
  logic [CHAIN_LEN-1:0] mask_q;
  // Only the N-1 earlier samples are stored; the last one comes straight
  // from SO on the edge that enters S_DONE.
  logic [CHAIN_LEN-2:0] cap_sr;
  logic [CHAIN_LEN-1:0] cap_next;
  logic                 mis_next;

`ifndef SCAN_CHAIN_CTRL_MASK_EN
  assign mask_q = '1;
`endif

  // Sample k shifts in at the LSB, so sample 0 ends up in the MSB.
  assign cap_next = {cap_sr, SO};
  assign mis_next = |((cap_next ^ exp_q) & mask_q);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= S_IDLE;
      cnt      <= '0;
      pat_sr   <= '0;
      exp_q    <= '0;
      cap_sr   <= '0;
      SE       <= 1'b0;
      SI       <= 1'b0;
      BUSY     <= 1'b0;
      DONE     <= 1'b0;
      CAP_OUT  <= '0;
      MISMATCH <= 1'b0;
`ifdef SCAN_CHAIN_CTRL_MASK_EN
      mask_q   <= '1;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          DONE <= 1'b0;
          if (START) begin
            state  <= S_SHIFT;
            SE     <= 1'b1;
            SI     <= PAT_IN[CHAIN_LEN-1];
            pat_sr <= {PAT_IN[CHAIN_LEN-2:0], 1'b0};
            exp_q  <= EXP_IN;
`ifdef SCAN_CHAIN_CTRL_MASK_EN
            mask_q <= MASK_IN;
`endif
            BUSY   <= 1'b1;
            cnt    <= CW'(CHAIN_LEN - 1);
          end
        end
        S_SHIFT: begin
          if (cnt == '0) begin
            state <= S_CAPTURE;
            SE    <= 1'b0;
            SI    <= 1'b0;
          end else begin
            cnt    <= cnt - CW'(1);
            SI     <= pat_sr[CHAIN_LEN-1];
            pat_sr <= {pat_sr[CHAIN_LEN-2:0], 1'b0};
          end
        end
        S_CAPTURE: begin
          cap_sr <= cap_next[CHAIN_LEN-2:0];
          state  <= S_UNLOAD;
          SE     <= 1'b1;
          cnt    <= CW'(CHAIN_LEN - 2);
        end
        S_UNLOAD: begin
          if (cnt == '0) begin
            state    <= S_DONE;
            SE       <= 1'b0;
            DONE     <= 1'b1;
            CAP_OUT  <= cap_next;
            MISMATCH <= mis_next;
          end else begin
            cap_sr <= cap_next[CHAIN_LEN-2:0];
            cnt    <= cnt - CW'(1);
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          DONE  <= 1'b0;
          BUSY  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          SE    <= 1'b0;
          SI    <= 1'b0;
          BUSY  <= 1'b0;
          DONE  <= 1'b0;
        end
      endcase
    end
  end

endmodule
